// File: rtl/sipo_frame_pkg.sv
// ---------------------------------------------------------------------------
// sipo_frame_pkg
// Shared definitions for the serial-in / parallel-out framer.
//   state_t        : framer FSM state encoding (IDLE, DATA, STOP)
//   DEFAULT_WIDTH  : default number of data bits per frame
//   cnt_width()    : bit counter width able to hold the values 0..width
// ---------------------------------------------------------------------------
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter must be able to reach 'width' itself, so it never wraps
  // before the frame reaches its stop bit.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// ---------------------------------------------------------------------------
// shift_reg_en
// WIDTH-bit shift register with shift enable, filled LSB-first: after WIDTH
// enabled shifts, the first bit shifted in sits in q[0].
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears q
//   en   : shift enable
//   din  : serial input bit
//   q    : parallel register contents
// ---------------------------------------------------------------------------
module shift_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // New bits enter at the MSB and move toward bit 0, so the oldest bit
  // ends up at the LSB once a full word has been shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame.sv
// ---------------------------------------------------------------------------
// sipo_frame
// Serial framer: waits for a 0 start bit, collects WIDTH data bits LSB-first,
// then checks a 1 stop bit. Good words are published on dout with a one-cycle
// valid pulse; a bad stop bit produces a one-cycle frame_err pulse instead.
// Only cycles with en=1 consume din.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   din       : serial data bit (already registered upstream)
//   en        : sample strobe
//   dout      : last correctly framed word, bit 0 = first data bit
//   valid     : one-cycle pulse, dout just updated
//   frame_err : one-cycle pulse, stop bit was 0 and the word was dropped
//   busy      : high while a frame is in progress
// ---------------------------------------------------------------------------
module sipo_frame
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en;

  // Data bits are only captured while collecting the word, never on the
  // start or stop bit.
  assign shift_en = en && (state == DATA);

  shift_reg_en #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .din (din),
    .q   (shift_q)
  );

  // Framer FSM with its counter and registered outputs. The pulses default
  // to 0 every cycle so they can never last longer than one clock, and all
  // state is frozen on cycles where en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (!din) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= STOP;
            end
          end
          STOP: begin
            // A 0 stop bit is not reused as the next start bit.
            if (din) begin
              dout  <= shift_q;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame
// Self-checking bench for sipo_frame. A frame-level reference model (a queue
// of collected data bits plus an "inside a frame" flag) predicts the outputs
// after every clock; scenario tasks also check their expected words directly.
// ---------------------------------------------------------------------------
module tb_sipo_frame;
  import sipo_frame_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;

  typedef bit bitq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             frame_err;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  bit               m_in_frame = 1'b0;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_dout  = '0;
  bit               m_valid = 1'b0;
  bit               m_err   = 1'b0;

  sipo_frame #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .en        (en),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Start bit, data bits LSB-first, then the given stop bit.
  function automatic bitq_t frame_bits(input logic [WIDTH-1:0] w, input bit stop);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) q.push_back(w[i]);
    q.push_back(stop);
    return q;
  endfunction

  // Drive one clock cycle and advance the reference model; outputs are
  // settled 1 time unit after the rising edge when this returns.
  task automatic step(input logic r, input logic e, input logic d);
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_dout = '0;
    end else if (e) begin
      if (!m_in_frame) begin
        if (!d) begin
          m_in_frame = 1'b1;
          m_bits.delete();
        end
      end else if (m_bits.size() < WIDTH) begin
        m_bits.push_back(d);
      end else begin
        if (d) begin
          for (int i = 0; i < WIDTH; i++) m_dout[i] = m_bits[i];
          m_valid = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_in_frame = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 1'b0);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
        tests_failed++;
        $display("[TB] FAIL reset cycle %0d: got v=%b e=%b b=%b d=%h, expected all zero", c, valid, frame_err, busy, dout);
      end
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_good_frame();
    bitq_t q;
    int pulses = 0;
    logic [WIDTH-1:0] word = '0;
    q = frame_bits(8'hA5, 1'b1);
    for (int i = 0; i < q.size(); i++) begin
      step(1'b0, 1'b1, q[i]);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
        tests_failed++;
        $display("[TB] FAIL good_frame bit %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", i, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
      end
      if (valid) begin pulses++; word = dout; end
    end
    step(1'b0, 1'b1, 1'b1);
    tests_run++;
    if (pulses != 1 || word !== 8'hA5 || valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL good_frame result: got pulses=%0d word=%h valid=%b busy=%b, expected 1 a5 0 0", pulses, word, valid, busy);
    end
  endtask

  task automatic test_sparse();
    bitq_t q;
    int pulses = 0;
    logic [WIDTH-1:0] word = '0;
    q = frame_bits(8'hA5, 1'b1);
    for (int i = 0; i < q.size(); i++) begin
      for (int k = 0; k < 3; k++) begin
        if (k < 2) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        else       step(1'b0, 1'b1, q[i]);
        tests_run++;
        if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
          tests_failed++;
          $display("[TB] FAIL sparse bit %0d slot %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", i, k, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
        end
        if (valid) begin pulses++; word = dout; end
      end
    end
    tests_run++;
    if (pulses != 1 || word !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL sparse result: got pulses=%0d word=%h, expected 1 a5", pulses, word);
    end
  endtask

  task automatic test_frame_err();
    bitq_t q;
    int vpulses = 0;
    int epulses = 0;
    q = frame_bits(8'hFF, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(1'b0, 1'b1, q[i]);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
        tests_failed++;
        $display("[TB] FAIL frame_err bit %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", i, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
      end
      if (valid) vpulses++;
      if (frame_err) epulses++;
    end
    step(1'b0, 1'b1, 1'b1);
    tests_run++;
    if (vpulses != 0 || epulses != 1 || frame_err !== 1'b0 || dout !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL frame_err result: got valid=%0d err=%0d err_now=%b dout=%h, expected 0 1 0 a5", vpulses, epulses, frame_err, dout);
    end
  endtask

  task automatic test_reset_mid_frame();
    bitq_t q;
    int vpulses = 0;
    int epulses = 0;
    logic [WIDTH-1:0] word = '0;
    q = frame_bits(8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, q[i]);
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({valid, frame_err, busy, dout} !== {1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_frame abort: got v=%b e=%b b=%b d=%h, expected all zero", valid, frame_err, busy, dout);
    end
    q = frame_bits(8'h81, 1'b1);
    q.push_front(1'b1);
    for (int i = 0; i < q.size(); i++) begin
      step(1'b0, 1'b1, q[i]);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_frame bit %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", i, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
      end
      if (valid) begin vpulses++; word = dout; end
      if (frame_err) epulses++;
    end
    tests_run++;
    if (vpulses != 1 || epulses != 0 || word !== 8'h81) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_frame result: got valid=%0d err=%0d word=%h, expected 1 0 81", vpulses, epulses, word);
    end
  endtask

  task automatic test_back_to_back();
    bitq_t q;
    bitq_t q2;
    logic [WIDTH-1:0] words[$];
    q  = frame_bits(8'h12, 1'b1);
    q2 = frame_bits(8'h34, 1'b1);
    foreach (q2[i]) q.push_back(q2[i]);
    for (int i = 0; i < q.size(); i++) begin
      step(1'b0, 1'b1, q[i]);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back bit %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", i, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
      end
      if (valid) words.push_back(dout);
    end
    tests_run++;
    if (words.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back count: got %0d pulses, expected 2", words.size());
    end else if (words[0] !== 8'h12 || words[1] !== 8'h34) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back words: got %h %h, expected 12 34", words[0], words[1]);
    end
  endtask

  task automatic test_random();
    logic r;
    logic e;
    logic d;
    logic prev_pulse = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      step(r, e, d);
      tests_run++;
      if ({valid, frame_err, busy, dout} !== {m_valid, m_err, m_in_frame, m_dout}) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: got v=%b e=%b b=%b d=%h, expected v=%b e=%b b=%b d=%h", c, valid, frame_err, busy, dout, m_valid, m_err, m_in_frame, m_dout);
      end
      if ((valid && frame_err) || (prev_pulse && (valid || frame_err))) begin
        tests_failed++;
        $display("[TB] FAIL random pulse_rule cycle %0d: got v=%b e=%b prev=%b, expected single exclusive pulses", c, valid, frame_err, prev_pulse);
      end
      prev_pulse = valid | frame_err;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_sparse();
    test_frame_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
